lcd_cmd_sched: RTL and testbench
================================

// Module: lcd_cmd_sched
// PURPOSE
//  Command scheduler in front of the 12x9 LCD zoom/shift controller (LCD_CTRL-class datapath).
//  Queues host commands in a small FIFO and issues each one to the LCD controller only while its
//  busy is low. For LOAD it streams the 108-byte image from a sync-read image ROM.
//  Re-emits the controller's 16-byte output window as indexed pixels with a per-frame done pulse.
// PARAMETERS
//  FIFO_DEPTH  4    host command FIFO entries (power of 2, >=2)
//  IMG_BYTES   108  bytes streamed per LOAD (12x9 image)
//  OUT_BYTES   16   bytes per output window (4x4)
//  WDOG_MAX    255  busy-timeout limit in cycles (used only with LCD_SCHED_WDOG_EN)
// PORTS
//  clk             in   1  rising-edge clock
//  reset           in   1  asynchronous, active-high reset
//  host_cmd        in   3  0 load, 1 zoom-in, 2 zoom-fit, 3 right, 4 left, 5 up, 6 down, 7 illegal
//  host_cmd_valid  in   1  push request
//  host_cmd_ready  out  1  FIFO not full; push accepted when valid&&ready
//  img_addr        out  7  image ROM address (data returned next cycle)
//  img_rd          out  1  image ROM read enable
//  img_data        in   8  image ROM read data
//  lcd_cmd         out  3  command to LCD controller
//  lcd_cmd_valid   out  1  one-cycle command strobe
//  lcd_datain      out  8  image byte to LCD controller
//  lcd_busy        in   1  LCD controller busy
//  lcd_dataout     in   8  LCD output byte
//  lcd_out_valid   in   1  LCD output byte valid
//  pix_data        out  8  registered output byte
//  pix_valid       out  1  pix_data valid
//  pix_idx         out  4  index 0..15 of pix_data within window
//  frame_done      out  1  one-cycle pulse with the 16th pixel of a window
//  err_cmd         out  1  one-cycle pulse when an illegal (7) command is dropped
//  err_wdog        out  1  sticky busy-timeout flag (0 when LCD_SCHED_WDOG_EN undefined)
// BEHAVIOUR
//  Reset: all outputs 0 except host_cmd_ready=1. FIFO empty, FSM=IDLE, counters 0.
//   Mid-operation reset aborts any LOAD or issue immediately. The queue contents are lost.
//  FIFO: push on host_cmd_valid&&host_cmd_ready. Push while full is ignored (ready=0).
//   Push and pop in the same cycle are both honoured when not full. Pointers wrap modulo FIFO_DEPTH.
//  FSM states IDLE -> ISSUE -> (LOAD) -> WAIT -> IDLE:
//   IDLE: if FIFO non-empty && !lcd_busy, pop the head entry.
//    Head==7: drop it, err_cmd=1 for 1 cycle, stay in IDLE.
//    Otherwise latch the command and go to ISSUE.
//   ISSUE: lcd_cmd=latched command, lcd_cmd_valid=1 for exactly 1 cycle.
//    If cmd==0, also img_rd=1 and img_addr=0; next state LOAD. Otherwise next state WAIT.
//   LOAD: img_addr increments by 1 per cycle up to IMG_BYTES-1, with img_rd=1.
//    lcd_datain=img_data combinationally, so byte k is on lcd_datain at ISSUE+1+k.
//    After addr IMG_BYTES-1 has been issued, go to WAIT. img_addr holds its last value.
//   WAIT: leave for IDLE on the first cycle lcd_busy==0 that comes at least 2 cycles after ISSUE.
//    The 2-cycle guard covers the controller's busy assertion latency.
//  lcd_cmd_valid is never asserted while lcd_busy==1.
//  Pixel path (independent of FSM): pix_data<=lcd_dataout and pix_valid<=lcd_out_valid, 1-cycle latency.
//   pix_idx counts valid pixels 0..15 and wraps to 0 after 15.
//   frame_done=1 in the same cycle as pix_valid with pix_idx==15.
//  Command-to-command gap: the next command is issued no earlier than the 2nd cycle after busy falls.
// CONFIGURATION
//  LCD_SCHED_WDOG_EN defined: a 8-bit counter runs in WAIT/LOAD while lcd_busy==1.
//   When it reaches WDOG_MAX: err_wdog<=1 (sticky until reset), FSM->IDLE, counter clears.
//   The FIFO is kept and issue resumes when lcd_busy drops.
//  Undefined: no counter, err_wdog tied 0, FSM waits on busy indefinitely.
// TESTING
//  1 reset held 3 cycles mid-LOAD -> all outputs 0, host_cmd_ready=1, no further lcd_cmd_valid.
//  2 push cmd 0, ROM[k]=k -> one lcd_cmd_valid with lcd_cmd=0; lcd_datain=0..107 on 108 consecutive cycles from ISSUE+1.
//  3 push 0,1,3,4 back-to-back with the model busy 130 cycles each -> cmds issued in order.
//    Each strobe comes only while busy=0; FIFO never overflows.
//  4 model emits 16 bytes 0xA0..0xAF -> pix_data same bytes 1 cycle later, pix_idx 0..15, frame_done on 0xAF only.
//  5 with FIFO_DEPTH=4 push 5 cmds while busy held high -> ready=0 after 4th; 5th dropped; push 7 -> err_cmd pulse, no issue.
//  6 LCD_SCHED_WDOG_EN, busy stuck high after ISSUE -> err_wdog=1 at WDOG_MAX cycles; undefined -> err_wdog stays 0.

Source files
------------

// File: rtl/lcd_cmd_sched_if.sv
// Bus bundle of lcd_cmd_sched: host command push, image ROM read, LCD controller command/data
// and the re-emitted pixel stream. The scheduler uses the slave modport.
interface lcd_cmd_sched_if;
    logic [2:0] host_cmd;
    logic       host_cmd_valid;
    logic       host_cmd_ready;
    logic [6:0] img_addr;
    logic       img_rd;
    logic [7:0] img_data;
    logic [2:0] lcd_cmd;
    logic       lcd_cmd_valid;
    logic [7:0] lcd_datain;
    logic       lcd_busy;
    logic [7:0] lcd_dataout;
    logic       lcd_out_valid;
    logic [7:0] pix_data;
    logic       pix_valid;
    logic [3:0] pix_idx;
    logic       frame_done;
    logic       err_cmd;
    logic       err_wdog;

    modport master (
        output host_cmd, host_cmd_valid, img_data, lcd_busy, lcd_dataout, lcd_out_valid,
        input  host_cmd_ready, img_addr, img_rd, lcd_cmd, lcd_cmd_valid, lcd_datain,
               pix_data, pix_valid, pix_idx, frame_done, err_cmd, err_wdog
    );

    modport slave (
        input  host_cmd, host_cmd_valid, img_data, lcd_busy, lcd_dataout, lcd_out_valid,
        output host_cmd_ready, img_addr, img_rd, lcd_cmd, lcd_cmd_valid, lcd_datain,
               pix_data, pix_valid, pix_idx, frame_done, err_cmd, err_wdog
    );
endinterface

// File: rtl/lcd_cmd_sched.sv
// Command scheduler for the 12x9 LCD zoom/shift controller: host FIFO, issue FSM with image
// streaming on LOAD, and pixel re-emit. Define LCD_SCHED_WDOG_EN to enable the busy watchdog.
module lcd_cmd_sched #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned IMG_BYTES  = 108,
    parameter int unsigned OUT_BYTES  = 16,
    parameter int unsigned WDOG_MAX   = 255
) (
    input  logic           clk,
    input  logic           reset,
    lcd_cmd_sched_if.slave bus
);
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned CMD_W  = 3;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned IDX_W  = 4;

    localparam logic [CMD_W-1:0]  CMD_LOAD    = CMD_W'(0);
    localparam logic [CMD_W-1:0]  CMD_ILLEGAL = CMD_W'(7);
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(IMG_BYTES - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(OUT_BYTES - 1);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        IMG_BYTES < 2 || IMG_BYTES > 128 || OUT_BYTES < 1 || OUT_BYTES > 16 ||
        WDOG_MAX < 1 || WDOG_MAX > 255) begin : g_param_check
        $error("lcd_cmd_sched: unsupported parameter value");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_LOAD, S_WAIT} state_e;

    // Host command FIFO
    logic [CMD_W-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full_c;
    logic             empty_c;
    logic             push_c;
    logic             pop_c;
    logic [CMD_W-1:0] head_c;

    state_e            state_q;
    logic [CMD_W-1:0]  lcd_cmd_q;
    logic              lcd_cmd_valid_q;
    logic              img_rd_q;
    logic [ADDR_W-1:0] img_addr_q;
    logic              rd_dly_q;
    logic [1:0]        since_q;
    logic              err_cmd_q;

    logic [7:0]        pix_data_q;
    logic              pix_valid_q;
    logic [IDX_W-1:0]  pix_idx_q;
    logic [IDX_W-1:0]  pix_cnt_q;
    logic              frame_done_q;

    assign full_c  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_c = (count_q == '0);
    assign push_c  = bus.host_cmd_valid && !full_c;
    assign pop_c   = (state_q == S_IDLE) && !empty_c && !bus.lcd_busy;
    assign head_c  = fifo_mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_mem_q[wr_ptr_q] <= bus.host_cmd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_c, pop_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef LCD_SCHED_WDOG_EN
    localparam int unsigned WDOG_W = 8;
    logic [WDOG_W-1:0] wdog_q;
    logic              err_wdog_q;
`endif

    // Issue FSM; outputs are registered so they are valid during the state they belong to
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            lcd_cmd_q       <= '0;
            lcd_cmd_valid_q <= 1'b0;
            img_rd_q        <= 1'b0;
            img_addr_q      <= '0;
            rd_dly_q        <= 1'b0;
            since_q         <= '0;
            err_cmd_q       <= 1'b0;
`ifdef LCD_SCHED_WDOG_EN
            wdog_q          <= '0;
            err_wdog_q      <= 1'b0;
`endif
        end else begin
            lcd_cmd_valid_q <= 1'b0;
            err_cmd_q       <= 1'b0;
            rd_dly_q        <= img_rd_q;
            if (since_q != 2'd2) since_q <= since_q + 2'd1;

            case (state_q)
                S_IDLE: begin
                    if (pop_c) begin
                        if (head_c == CMD_ILLEGAL) begin
                            err_cmd_q <= 1'b1;
                        end else begin
                            lcd_cmd_q       <= head_c;
                            lcd_cmd_valid_q <= 1'b1;
                            since_q         <= '0;
                            state_q         <= S_ISSUE;
                            if (head_c == CMD_LOAD) begin
                                img_rd_q   <= 1'b1;
                                img_addr_q <= '0;
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    if (lcd_cmd_q == CMD_LOAD) begin
                        img_addr_q <= ADDR_W'(1);
                        state_q    <= S_LOAD;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_LOAD: begin
                    if (img_addr_q == LAST_ADDR) begin
                        img_rd_q <= 1'b0;
                        state_q  <= S_WAIT;
                    end else begin
                        img_addr_q <= img_addr_q + ADDR_W'(1);
                    end
                end
                S_WAIT: begin
                    // Busy from the controller lags the strobe, so ignore it for two cycles
                    if (since_q == 2'd2 && !bus.lcd_busy) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

`ifdef LCD_SCHED_WDOG_EN
            if (state_q == S_WAIT || state_q == S_LOAD) begin
                if (bus.lcd_busy) begin
                    if (wdog_q == WDOG_W'(WDOG_MAX)) begin
                        err_wdog_q <= 1'b1;
                        wdog_q     <= '0;
                        img_rd_q   <= 1'b0;
                        state_q    <= S_IDLE;
                    end else begin
                        wdog_q <= wdog_q + WDOG_W'(1);
                    end
                end
            end else begin
                wdog_q <= '0;
            end
`endif
        end
    end

    // Pixel re-emit with window index and end-of-window pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_data_q   <= '0;
            pix_valid_q  <= 1'b0;
            pix_idx_q    <= '0;
            pix_cnt_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            pix_data_q   <= bus.lcd_dataout;
            pix_valid_q  <= bus.lcd_out_valid;
            frame_done_q <= 1'b0;
            if (bus.lcd_out_valid) begin
                pix_idx_q    <= pix_cnt_q;
                frame_done_q <= (pix_cnt_q == LAST_IDX);
                pix_cnt_q    <= (pix_cnt_q == LAST_IDX) ? '0 : pix_cnt_q + IDX_W'(1);
            end
        end
    end

    assign bus.host_cmd_ready = !full_c;
    assign bus.img_addr       = img_addr_q;
    assign bus.img_rd         = img_rd_q;
    assign bus.lcd_cmd        = lcd_cmd_q;
    assign bus.lcd_cmd_valid  = lcd_cmd_valid_q;
    // ROM data is passed straight through, only in the cycle after each read
    assign bus.lcd_datain     = rd_dly_q ? bus.img_data : 8'h00;
    assign bus.pix_data       = pix_data_q;
    assign bus.pix_valid      = pix_valid_q;
    assign bus.pix_idx        = pix_idx_q;
    assign bus.frame_done     = frame_done_q;
    assign bus.err_cmd        = err_cmd_q;
`ifdef LCD_SCHED_WDOG_EN
    assign bus.err_wdog       = err_wdog_q;
`else
    assign bus.err_wdog       = 1'b0;
`endif
endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Directed bench for lcd_cmd_sched: ROM model (ROM[k]=k), LCD busy model, strobe monitor.
module tb_lcd_cmd_sched;
    logic clk = 1'b0;
    logic reset;

    lcd_cmd_sched_if bus();

    lcd_cmd_sched dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    int         busy_cnt = 0;
    int         busy_len;
    logic       busy_force;
    int         cyc = 0;
    int         busy_viol = 0;
    int         err_cmd_cnt = 0;
    logic [2:0] strobe_log[$];
    int         strobe_cyc[$];

    // LCD controller busy: busy_len cycles after every command strobe
    always @(posedge clk or posedge reset) begin
        if (reset)                  busy_cnt <= 0;
        else if (bus.lcd_cmd_valid) busy_cnt <= busy_len;
        else if (busy_cnt != 0)     busy_cnt <= busy_cnt - 1;
    end
    assign bus.lcd_busy = busy_force || (busy_cnt != 0);

    always @(posedge clk) begin
        if (bus.img_rd) bus.img_data <= {1'b0, bus.img_addr};
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.lcd_cmd_valid) begin
            strobe_log.push_back(bus.lcd_cmd);
            strobe_cyc.push_back(cyc);
            if (bus.lcd_busy) busy_viol++;
        end
        if (bus.err_cmd) err_cmd_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_one(input logic [2:0] c, output logic rdy);
        bus.host_cmd       = c;
        bus.host_cmd_valid = 1'b1;
        rdy                = bus.host_cmd_ready;
        @(negedge clk);
    endtask

    task automatic wait_strobe(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (bus.lcd_cmd_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ctl"}, 64'({bus.host_cmd_ready, bus.img_rd, bus.img_addr, bus.lcd_cmd_valid,
                                bus.lcd_cmd, bus.lcd_datain}), 64'h10_0000);
        chk({tag, "_pix"}, 64'({bus.pix_valid, bus.pix_data, bus.pix_idx, bus.frame_done,
                                bus.err_cmd, bus.err_wdog}), 64'h0);
    endtask

    initial begin
        bit   ok;
        logic r0, r1, r2, r3, r4;
        int   bad;
        int   s;
        int   e0;

        reset              = 1'b1;
        bus.host_cmd       = '0;
        bus.host_cmd_valid = 1'b0;
        bus.lcd_dataout    = '0;
        bus.lcd_out_valid  = 1'b0;
        busy_force         = 1'b0;
        busy_len           = 120;
        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        reset = 1'b0;
        @(negedge clk);

        // LOAD: one strobe, then bytes 0..107 from ISSUE+1
        push_one(3'd0, r0);
        bus.host_cmd_valid = 1'b0;
        chk("t2_push_ready", 64'(r0), 64'd1);
        wait_strobe(50, ok);
        chk("t2_strobe", 64'(ok), 64'd1);
        chk("t2_issue", 64'({bus.lcd_cmd, bus.img_rd, bus.img_addr}), 64'({3'd0, 1'b1, 7'd0}));
        bad = 0;
        for (int k = 0; k < 108; k++) begin
            @(negedge clk);
            if (bus.lcd_datain !== 8'(k)) bad++;
        end
        chk("t2_stream_bad_bytes", 64'(bad), 64'd0);
        chk("t2_load_end", 64'({bus.img_rd, bus.img_addr}), 64'({1'b0, 7'd107}));
        @(negedge clk);
        chk("t2_datain_idle", 64'(bus.lcd_datain), 64'd0);
        chk("t2_one_strobe", 64'(strobe_log.size()), 64'd1);
        repeat (150) @(negedge clk);

        // Pixel window 0xA0..0xAF
        for (int i = 0; i < 17; i++) begin
            if (i > 0) begin
                chk("t4_pix", 64'({bus.pix_valid, bus.frame_done, bus.pix_idx, bus.pix_data}),
                    64'({1'b1, 1'(i == 16), 4'(i - 1), 8'(8'hA0 + i - 1)}));
            end
            if (i < 16) begin
                bus.lcd_out_valid = 1'b1;
                bus.lcd_dataout   = 8'(8'hA0 + i);
            end else begin
                bus.lcd_out_valid = 1'b0;
                bus.lcd_dataout   = 8'h00;
            end
            @(negedge clk);
        end
        chk("t4_after", 64'({bus.pix_valid, bus.frame_done}), 64'd0);

        // Back-to-back 0,1,3,4 with 130-cycle busy
        strobe_log.delete();
        strobe_cyc.delete();
        busy_len = 130;
        push_one(3'd0, r0);
        push_one(3'd1, r1);
        push_one(3'd3, r2);
        push_one(3'd4, r3);
        bus.host_cmd_valid = 1'b0;
        chk("t3_ready", 64'({r0, r1, r2, r3}), 64'hF);
        for (int i = 0; i < 800 && strobe_log.size() < 4; i++) @(negedge clk);
        chk("t3_count", 64'(strobe_log.size()), 64'd4);
        if (strobe_log.size() >= 4) begin
            chk("t3_order", 64'({strobe_log[0], strobe_log[1], strobe_log[2], strobe_log[3]}), 64'h05C);
            for (int i = 1; i < 4; i++) chk("t3_gap", 64'(strobe_cyc[i] - strobe_cyc[i-1]), 64'd133);
        end
        repeat (150) @(negedge clk);

        // Overflow while busy, then illegal command
        strobe_log.delete();
        busy_force = 1'b1;
        @(negedge clk);
        push_one(3'd5, r0);
        push_one(3'd6, r1);
        push_one(3'd1, r2);
        push_one(3'd2, r3);
        push_one(3'd3, r4);
        bus.host_cmd_valid = 1'b0;
        chk("t5_ready", 64'({r0, r1, r2, r3, r4}), 64'b11110);
        chk("t5_full", 64'(bus.host_cmd_ready), 64'd0);
        repeat (5) @(negedge clk);
        chk("t5_no_issue_busy", 64'(strobe_log.size()), 64'd0);
        busy_force = 1'b0;
        for (int i = 0; i < 700 && strobe_log.size() < 4; i++) @(negedge clk);
        repeat (150) @(negedge clk);
        chk("t5_count", 64'(strobe_log.size()), 64'd4);
        if (strobe_log.size() >= 4) begin
            chk("t5_order", 64'({strobe_log[0], strobe_log[1], strobe_log[2], strobe_log[3]}), 64'hB8A);
        end
        e0 = err_cmd_cnt;
        push_one(3'd7, r0);
        bus.host_cmd_valid = 1'b0;
        chk("t5_err_pre", 64'(bus.err_cmd), 64'd0);
        @(negedge clk);
        chk("t5_err_pulse", 64'(bus.err_cmd), 64'd1);
        @(negedge clk);
        chk("t5_err_post", 64'(bus.err_cmd), 64'd0);
        repeat (20) @(negedge clk);
        chk("t5_err_count", 64'(err_cmd_cnt - e0), 64'd1);
        chk("t5_illegal_not_issued", 64'(strobe_log.size()), 64'd4);

        // Reset held 3 cycles in the middle of a LOAD
        strobe_log.delete();
        busy_len = 120;
        push_one(3'd0, r0);
        bus.host_cmd_valid = 1'b0;
        wait_strobe(50, ok);
        chk("t1_strobe", 64'(ok), 64'd1);
        repeat (20) @(negedge clk);
        chk("t1_mid_load", 64'(bus.img_rd), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs("t1_rst");
        repeat (2) @(negedge clk);
        chk_reset_outputs("t1_rst_hold");
        reset = 1'b0;
        s = strobe_log.size();
        repeat (40) @(negedge clk);
        chk("t1_no_issue", 64'(strobe_log.size()), 64'(s));
        chk("t1_idle", 64'({bus.img_rd, bus.lcd_cmd_valid, bus.lcd_datain}), 64'd0);

        // Busy stuck high after issue
        push_one(3'd1, r0);
        bus.host_cmd_valid = 1'b0;
        wait_strobe(50, ok);
        chk("t6_strobe", 64'(ok), 64'd1);
        @(negedge clk);
        busy_force = 1'b1;
        repeat (249) @(negedge clk);
        chk("t6_wdog_early", 64'(bus.err_wdog), 64'd0);
        repeat (50) @(negedge clk);
`ifdef LCD_SCHED_WDOG_EN
        chk("t6_wdog", 64'(bus.err_wdog), 64'd1);
`else
        chk("t6_wdog", 64'(bus.err_wdog), 64'd0);
`endif

        chk("busy_violations", 64'(busy_viol), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
